// File: rtl/digi_ota_pkg.sv
// Shared types and constants for the OTA duty-cycle meter.
package digi_ota_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int WIN_LOG2_DEF = 8;
  localparam int OUT_W_DEF    = 8;
  localparam int FILT_LEN_DEF = 3;

  localparam logic [7:0] EDGE_MAX = 8'd255;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
    return (inc && (v != EDGE_MAX)) ? (v + 8'd1) : v;
  endfunction

endpackage

// File: rtl/digi_ota_duty_meter_if.sv
// Control/result bundle between the tile logic and the duty meter.
interface digi_ota_duty_meter_if import digi_ota_pkg::*; #(
  parameter int OUT_W = OUT_W_DEF
) ();
  logic             ena;
  logic             cmp_in;
  logic             start;
  logic             cont;
  logic [OUT_W-1:0] dout;
  logic [7:0]       edges;
  logic             dout_valid;
  logic             busy;

  modport master (
    output ena, cmp_in, start, cont,
    input  dout, edges, dout_valid, busy
  );

  modport slave (
    input  ena, cmp_in, start, cont,
    output dout, edges, dout_valid, busy
  );
endinterface

// File: rtl/digi_ota_sync_filt.sv
// Two-flop synchroniser, run-length de-glitch filter and rising-edge detect
// for the asynchronous comparator bit.
module digi_ota_sync_filt import digi_ota_pkg::*; #(
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic d_async,
  output logic f,
  output logic rise
);

  localparam logic [2:0] RUN_LAST = 3'(FILT_LEN - 1);

  logic       s1_q, s2_q, f_q, fdly_q;
  logic       s1_d, s2_d, f_d, fdly_d;
  logic [2:0] run_q, run_d;

  // Next state; run_q counts consecutive synced samples that disagree with f.
  always_comb begin
    s1_d   = d_async;
    s2_d   = s1_q;
    fdly_d = f_q;
    f_d    = f_q;
    run_d  = run_q;
    if (s2_q == f_q) begin
      run_d = 3'd0;
    end else if (run_q == RUN_LAST) begin
      f_d   = s2_q;
      run_d = 3'd0;
    end else begin
      run_d = run_q + 3'd1;
    end
  end

  // State registers, frozen while ena is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      f_q    <= 1'b0;
      fdly_q <= 1'b0;
      run_q  <= 3'd0;
    end else if (ena) begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      f_q    <= f_d;
      fdly_q <= fdly_d;
      run_q  <= run_d;
    end
  end

  assign f    = f_q;
  assign rise = f_q & ~fdly_q;

endmodule

// File: rtl/digi_ota_duty_meter.sv
// Duty-cycle meter: counts filtered-high samples and rising edges over a
// window of 2^WIN_LOG2 enabled clocks and reports a scaled, saturated code.
module digi_ota_duty_meter import digi_ota_pkg::*; #(
  parameter int WIN_LOG2 = WIN_LOG2_DEF,
  parameter int OUT_W    = OUT_W_DEF,
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  digi_ota_duty_meter_if.slave  bus
);

  localparam int                   SHIFT    = WIN_LOG2 - OUT_W;
  localparam logic [WIN_LOG2-1:0]  WIN_LAST = {WIN_LOG2{1'b1}};
  localparam logic [WIN_LOG2-1:0]  WIN_ONE  = {{(WIN_LOG2-1){1'b0}}, 1'b1};
  localparam logic [WIN_LOG2:0]    DOUT_MAX = (WIN_LOG2+1)'((1 << OUT_W) - 1);

  state_e              state_q, state_d;
  logic [WIN_LOG2-1:0] win_q, win_d;
  logic [WIN_LOG2:0]   hi_q, hi_d;
  logic [7:0]          edge_q, edge_d;
  logic [OUT_W-1:0]    dout_q, dout_d;
  logic [7:0]          edges_q, edges_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;

  logic                f_s, rise_s;
  logic [WIN_LOG2:0]   hi_add_s;
  logic [WIN_LOG2:0]   scaled_s;
  logic [7:0]          edge_add_s;

  digi_ota_sync_filt #(.FILT_LEN(FILT_LEN)) u_sync_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (bus.ena),
    .d_async (bus.cmp_in),
    .f       (f_s),
    .rise    (rise_s)
  );

  // Running sums including this cycle's sample, and the scaled result.
  always_comb begin
    hi_add_s   = hi_q + {{WIN_LOG2{1'b0}}, f_s};
    edge_add_s = sat_inc8(edge_q, rise_s);
    scaled_s   = hi_add_s >> SHIFT;
  end

  // FSM next state, counters and result latching.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    hi_d    = hi_q;
    edge_d  = edge_q;
    dout_d  = dout_q;
    edges_d = edges_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = MEASURE;
          win_d   = '0;
          hi_d    = '0;
          edge_d  = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      MEASURE: begin
        win_d  = win_q + WIN_ONE;
        hi_d   = hi_add_s;
        edge_d = edge_add_s;
        if (win_q == WIN_LAST) begin
          state_d = DONE;
          valid_d = 1'b1;
          edges_d = edge_add_s;
          dout_d  = (scaled_s > DOUT_MAX) ? DOUT_MAX[OUT_W-1:0] : scaled_s[OUT_W-1:0];
        end else begin
          state_d = MEASURE;
        end
      end
      DONE: begin
        win_d   = '0;
        hi_d    = '0;
        edge_d  = 8'd0;
        state_d = bus.cont ? MEASURE : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; ena low freezes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      hi_q    <= '0;
      edge_q  <= 8'd0;
      dout_q  <= '0;
      edges_q <= 8'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (bus.ena) begin
      state_q <= state_d;
      win_q   <= win_d;
      hi_q    <= hi_d;
      edge_q  <= edge_d;
      dout_q  <= dout_d;
      edges_q <= edges_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // A DONE held by ena=0 must not present a valid pulse until ena returns.
  assign bus.dout_valid = valid_q & bus.ena;
  assign bus.dout       = dout_q;
  assign bus.edges      = edges_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_digi_ota_duty_meter.sv
// Self-checking bench: a window-level reference model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_digi_ota_duty_meter;
  import digi_ota_pkg::*;

  localparam int WL    = 8;
  localparam int OW    = 8;
  localparam int FL    = 3;
  localparam int WIN_N = 1 << WL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   cmp_mode = 0;

  digi_ota_duty_meter_if #(.OUT_W(OW)) bus ();

  digi_ota_duty_meter #(.WIN_LOG2(WL), .OUT_W(OW), .FILT_LEN(FL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // ---------------- comparator waveform generator ----------------
  int gen_cnt = 0;
  int run_left = 0;
  initial begin
    bus.cmp_in = 1'b0;
    forever begin
      tick();
      gen_cnt++;
      case (cmp_mode)
        0: bus.cmp_in = 1'b0;
        1: bus.cmp_in = 1'b1;
        2: bus.cmp_in = ((gen_cnt % 8) < 4);
        3: bus.cmp_in = ((gen_cnt % 16) < 2);
        4: bus.cmp_in = ((gen_cnt % 16) < 4);
        default: begin
          if (run_left == 0) begin
            bus.cmp_in = ~bus.cmp_in;
            run_left = $urandom_range(1, 10);
          end else begin
            run_left--;
          end
        end
      endcase
    end
  end

  // ---------------- reference model ----------------
  // hist[i] = cmp_in sampled i enabled edges ago; f follows the synced
  // stream (cmp_in two edges late) once FL consecutive samples agree.
  bit       m_known = 1'b0;
  int       m_phase = 0;          // 0 idle, 1 counting, 2 reporting
  bit [8:0] m_hist;
  bit       m_f1, m_f2;
  int       m_n, m_hi, m_edges;
  int       exp_dout, exp_edges;
  bit       mf_s, mrise_s, all1, all0;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_known = 1'b1;
        m_phase = 0;
        m_hist = '0;
        m_f1 = 1'b0;
        m_f2 = 1'b0;
        m_n = 0; m_hi = 0; m_edges = 0;
        exp_dout = 0; exp_edges = 0;
      end else if (m_known && bus.ena) begin
        mf_s    = m_f1;
        mrise_s = m_f1 && !m_f2;
        case (m_phase)
          0: if (bus.start) begin
               m_phase = 1; m_n = 0; m_hi = 0; m_edges = 0;
             end
          1: begin
               m_hi += int'(mf_s);
               if (mrise_s && m_edges < 255) m_edges++;
               m_n++;
               if (m_n == WIN_N) begin
                 exp_dout = m_hi >> (WL - OW);
                 if (exp_dout > (1 << OW) - 1) exp_dout = (1 << OW) - 1;
                 exp_edges = m_edges;
                 m_phase = 2;
               end
             end
          default: begin
               m_phase = bus.cont ? 1 : 0;
               m_n = 0; m_hi = 0; m_edges = 0;
             end
        endcase
        m_hist = {m_hist[7:0], bus.cmp_in};
        all1 = 1'b1;
        all0 = 1'b1;
        for (int i = 2; i <= FL + 1; i++) begin
          if (m_hist[i]) all0 = 1'b0;
          else           all1 = 1'b0;
        end
        m_f2 = m_f1;
        if (all1)      m_f1 = 1'b1;
        else if (all0) m_f1 = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_known) begin
        chk("dout",       int'(bus.dout),       exp_dout);
        chk("edges",      int'(bus.edges),      exp_edges);
        chk("dout_valid", int'(bus.dout_valid), int'((m_phase == 2) && bus.ena));
        chk("busy",       int'(bus.busy),       int'(m_phase != 0));
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic pulse_start(output int t0);
    bus.start = 1'b1;
    tick();
    t0 = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int limit,
                            output int t, output int d, output int e);
    t = -1; d = -1; e = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (bus.dout_valid) begin
        t = cyc; d = int'(bus.dout); e = int'(bus.edges);
        break;
      end
    end
    if (t < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no dout_valid within %0d cycles", nm, limit);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int t0, t1, t2, t3, d, e, nvalid;

  initial begin
    bus.ena = 1'b1; bus.start = 1'b0; bus.cont = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_dout", int'(bus.dout), 0);
    chk("rst_edges", int'(bus.edges), 0);
    chk("rst_valid", int'(bus.dout_valid), 0);

    // Empty window, single shot.
    cmp_mode = 0;
    repeat (10) tick();
    pulse_start(t0);
    wait_valid("empty", 400, t1, d, e);
    chk("empty_latency", t1 - t0, 256);
    chk("empty_dout", d, 0);
    chk("empty_edges", e, 0);
    chk("single_busy_at_valid", int'(bus.busy), 1);
    tick();
    chk("single_busy_after", int'(bus.busy), 0);

    // Full window: f already high before the window.
    cmp_mode = 1;
    repeat (10) tick();
    pulse_start(t0);
    wait_valid("full", 400, t1, d, e);
    chk("full_dout", d, 255);
    chk("full_edges", e, 0);

    // start during MEASURE is ignored.
    repeat (3) tick();
    pulse_start(t0);
    repeat (100) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_valid("restart", 400, t1, d, e);
    chk("restart_latency", t1 - t0, 256);
    chk("restart_dout", d, 255);

    // ena gap of 50 cycles mid-window.
    repeat (3) tick();
    pulse_start(t0);
    repeat (100) tick();
    bus.ena = 1'b0;
    repeat (50) tick();
    bus.ena = 1'b1;
    wait_valid("ena_gap", 500, t1, d, e);
    chk("ena_gap_latency", t1 - t0, 306);
    chk("ena_gap_dout", d, 255);
    chk("ena_gap_edges", e, 0);

    // Square wave, continuous windows.
    cmp_mode = 2;
    repeat (16) tick();
    bus.cont = 1'b1;
    pulse_start(t0);
    wait_valid("sq1", 400, t1, d, e);
    chk("sq1_dout", d, 128);
    chk("sq1_edges", e, 32);
    wait_valid("sq2", 400, t2, d, e);
    chk("sq2_dout", d, 128);
    chk("sq2_edges", e, 32);
    chk("sq_spacing12", t2 - t1, 257);
    wait_valid("sq3", 400, t3, d, e);
    chk("sq3_edges", e, 32);
    chk("sq_spacing23", t3 - t2, 257);
    bus.cont = 1'b0;
    tick();
    chk("sq_stop_busy", int'(bus.busy), 0);

    // Glitch rejection: 2-cycle pulses vanish, 4-cycle pulses pass.
    cmp_mode = 3;
    repeat (20) tick();
    pulse_start(t0);
    wait_valid("glitch2", 400, t1, d, e);
    chk("glitch2_dout", d, 0);
    chk("glitch2_edges", e, 0);
    cmp_mode = 4;
    repeat (20) tick();
    pulse_start(t0);
    wait_valid("pulse4", 400, t1, d, e);
    chk("pulse4_dout", d, 64);
    chk("pulse4_edges", e, 16);

    // Reset mid-window discards the partial result.
    cmp_mode = 1;
    repeat (5) tick();
    pulse_start(t0);
    repeat (100) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_dout", int'(bus.dout), 0);
    chk("midrst_edges", int'(bus.edges), 0);
    nvalid = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.dout_valid) nvalid++;
    end
    chk("midrst_no_valid", nvalid, 0);

    // Randomised traffic checked by the model.
    cmp_mode = 5;
    for (int i = 0; i < 3000; i++) begin
      bus.ena   = ($urandom_range(0, 9) != 0);
      bus.start = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) bus.cont = ~bus.cont;
      rst_n = ($urandom_range(0, 1499) != 0);
      tick();
    end
    bus.ena = 1'b1; bus.start = 1'b0; rst_n = 1'b1;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
